rx_xfer_ctrl: RTL and testbench

- cpu_clk-domain scheduler that drains the shared rx audio sample buffer toward the SPI transmit path.
- Issues buffer resets, tracks the writer's completed-buffer count against its own read count, and meters get_rx_samp_C read strobes under downstream backpressure.
- Appends the buffer-counter word to each transfer and raises sticky overrun when the writer laps the reader.
- Sits between the eCPU command decoder and the rx audio memory read port.

---
 rtl/rx_xfer_ctrl_pkg.sv | 13 +
 rtl/rx_xfer_credit.sv | 26 ++
 rtl/rx_xfer_ctrl.sv | 72 +++++++
 tb/tb_rx_xfer_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_xfer_ctrl_pkg.sv
// rx_xfer_ctrl_pkg: shared state encoding and sizing for the rx sample buffer drain
package rx_xfer_ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RST = 3'd1;
  localparam logic [2:0] RST_HOLD = 3'd2;
  localparam logic [2:0] WAIT_AV = 3'd3;
  localparam logic [2:0] READ = 3'd4;
  localparam logic [2:0] CTR = 3'd5;
  localparam int RXBUF_SIZE = 8192;
  localparam int DEF_XFER_WORDS = 1012;
  localparam int CTR_W = 16;
endpackage

// File: rtl/rx_xfer_credit.sv
// rx_xfer_credit: reader-side buffer credit (read count, registered avail, sticky overrun)
module rx_xfer_credit import rx_xfer_ctrl_pkg::*; #(
  parameter int MAX_AHEAD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CTR_W-1:0] buf_ctr,
  output logic [CTR_W-1:0] avail,
  output logic             overrun
);
  logic [CTR_W-1:0] rd_ctr;
  // clr also zeroes avail so a stale pre-clear difference cannot re-arm overrun
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ctr <= '0;
      avail <= '0;
      overrun <= 1'b0;
    end else begin
      rd_ctr <= rd_ctr + CTR_W'(inc);
      avail <= buf_ctr - rd_ctr;
      overrun <= overrun | (avail > CTR_W'(MAX_AHEAD));
    end
  end
endmodule

// File: rtl/rx_xfer_ctrl.sv
// rx_xfer_ctrl: schedules rx sample buffer reads toward the SPI path, one transfer per start
module rx_xfer_ctrl import rx_xfer_ctrl_pkg::*; #(
  parameter int MAX_AHEAD = RXBUF_SIZE / DEF_XFER_WORDS,
  parameter int RST_WAIT = 8,
  parameter int LEN_W = 11
) (
  input  logic             cpu_clk,
  input  logic             reset_C,
  input  logic             init_C,
  input  logic             start_C,
  input  logic [LEN_W-1:0] xfer_words_C,
  input  logic [CTR_W-1:0] buf_ctr_C,
  input  logic             spi_ready_C,
  output logic             reset_bufs_C,
  output logic             get_rx_samp_C,
  output logic             get_buf_ctr_C,
  output logic             busy_C,
  output logic             done_C,
  output logic [CTR_W-1:0] avail_C,
  output logic             overrun_C
);
  localparam int WAIT_W = $clog2(RST_WAIT + 1);
  state_t state;
  logic [LEN_W-1:0] words;
  logic [WAIT_W-1:0] wait_ctr;
  assign busy_C = state != IDLE;
  assign reset_bufs_C = state == RST;
  assign get_rx_samp_C = state == READ && spi_ready_C;
  assign get_buf_ctr_C = state == CTR && spi_ready_C;
  // an aborted counter-word cycle neither completes nor consumes a buffer
  assign done_C = get_buf_ctr_C && !init_C && !reset_C;
  rx_xfer_credit #(.MAX_AHEAD(MAX_AHEAD)) u_credit (
    .clk(cpu_clk),
    .rst(reset_C),
    .clr(reset_bufs_C),
    .inc(done_C),
    .buf_ctr(buf_ctr_C),
    .avail(avail_C),
    .overrun(overrun_C)
  );
  always_ff @(posedge cpu_clk) begin
    if (reset_C) begin
      state <= IDLE;
      words <= '0;
      wait_ctr <= '0;
    end else if (init_C) begin
      state <= RST;
      words <= '0;
    end else begin
      case (state)
        RST: begin
          wait_ctr <= WAIT_W'(RST_WAIT);
          state <= RST_HOLD;
        end
        RST_HOLD: begin
          wait_ctr <= wait_ctr - 1'b1;
          if (wait_ctr <= WAIT_W'(1)) state <= IDLE;
        end
        WAIT_AV: if (|avail_C) begin
          words <= xfer_words_C;
          state <= |xfer_words_C ? READ : CTR;
        end
        READ: if (spi_ready_C) begin
          words <= words - 1'b1;
          if (words == LEN_W'(1)) state <= CTR;
        end
        CTR: if (spi_ready_C) state <= IDLE;
        default: state <= start_C ? WAIT_AV : IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_xfer_ctrl.sv
// tb_rx_xfer_ctrl: randomized transfer scoreboard for rx_xfer_ctrl
module tb_rx_xfer_ctrl;
  logic cpu_clk = 1'b0;
  logic reset_C, init_C, start_C, spi_ready_C;
  logic [10:0] xfer_words_C;
  logic [15:0] buf_ctr_C;
  logic reset_bufs_C, get_rx_samp_C, get_buf_ctr_C, busy_C, done_C, overrun_C;
  logic [15:0] avail_C;
  int total = 0;
  int bad = 0;
  logic [15:0] rd_m = '0;
  int rb, bz, st, rx, lat, dn;
  bit found;
  rx_xfer_ctrl dut (
    .cpu_clk(cpu_clk),
    .reset_C(reset_C),
    .init_C(init_C),
    .start_C(start_C),
    .xfer_words_C(xfer_words_C),
    .buf_ctr_C(buf_ctr_C),
    .spi_ready_C(spi_ready_C),
    .reset_bufs_C(reset_bufs_C),
    .get_rx_samp_C(get_rx_samp_C),
    .get_buf_ctr_C(get_buf_ctr_C),
    .busy_C(busy_C),
    .done_C(done_C),
    .avail_C(avail_C),
    .overrun_C(overrun_C)
  );
  always #5 cpu_clk = ~cpu_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic rst, input logic init, input logic start, input logic ready);
    @(posedge cpu_clk);
    #1;
    reset_C = rst;
    init_C = init;
    start_C = start;
    spi_ready_C = ready;
    #1;
  endtask
  task automatic settle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1);
  endtask
  // one transfer scored by totals: n samples then exactly one counter word carrying done
  task automatic run_xfer(input int n, input int mode);
    int rxc = 0, ctr = 0, dnc = 0, low = 0, late = 0, cyc = 0;
    bit fin = 0;
    logic rdy;
    xfer_words_C = 11'(n);
    drive(0, 0, 1, 1);
    while (!fin && cyc < 4 * n + 50) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      drive(0, 0, mode == 2 && $urandom_range(0, 15) == 0, rdy);
      if (cyc == 3) xfer_words_C = 11'($urandom);
      if (get_rx_samp_C) begin
        rxc++;
        if (!rdy) low++;
        if (ctr > 0) late++;
      end
      if (get_buf_ctr_C) begin
        ctr++;
        if (!rdy) low++;
      end
      if (done_C) begin
        dnc++;
        if (!get_buf_ctr_C || rxc != n) late++;
        fin = 1;
      end
      cyc++;
    end
    check("xfer_done", 32'(fin), 1);
    if (fin) rd_m = rd_m + 16'd1;
    check("rx_strobes", 32'(rxc), 32'(n));
    check("ctr_strobes", 32'(ctr), 1);
    check("done_pulses", 32'(dnc), 1);
    check("strobe_ready_low", 32'(low), 0);
    check("strobe_order", 32'(late), 0);
    drive(0, 0, 0, 1);
    check("idle_after", 32'(busy_C), 0);
    drive(0, 0, 0, 1);
    check("avail_after", 32'(avail_C), 32'(buf_ctr_C - rd_m));
  endtask
  initial begin
    reset_C = 1;
    init_C = 0;
    start_C = 0;
    spi_ready_C = 0;
    xfer_words_C = 11'd2;
    buf_ctr_C = 16'd1;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 1);
    check("reset_out", 32'({reset_bufs_C, get_rx_samp_C, get_buf_ctr_C, busy_C, done_C, overrun_C, avail_C}), 0);
    drive(0, 1, 1, 1);
    rb = 0;
    bz = 0;
    st = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, i == 4, 1);
      rb += int'(reset_bufs_C);
      bz += int'(busy_C);
      st += int'(get_rx_samp_C) + int'(get_buf_ctr_C);
    end
    check("init_reset_bufs", 32'(rb), 1);
    check("init_busy", 32'(bz), 9);
    check("init_hold_strobes", 32'(st), 0);
    run_xfer(1011, 0);
    buf_ctr_C = 16'd2;
    settle(2);
    run_xfer(1011, 1);
    xfer_words_C = 11'd3;
    drive(0, 0, 1, 1);
    bz = 0;
    st = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1);
      bz += int'(busy_C);
      st += int'(get_rx_samp_C) + int'(get_buf_ctr_C);
    end
    check("stall_busy", 32'(bz), 6);
    check("stall_strobes", 32'(st), 0);
    buf_ctr_C = buf_ctr_C + 16'd1;
    lat = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(0, 0, 0, 1);
      lat++;
      found = get_rx_samp_C;
    end
    check("first_strobe_lat", 32'(lat), 2);
    rx = 1;
    dn = 0;
    for (int i = 0; i < 20 && dn == 0; i++) begin
      drive(0, 0, 0, 1);
      rx += int'(get_rx_samp_C);
      dn += int'(done_C);
    end
    check("stall_rx", 32'(rx), 3);
    check("stall_done", 32'(dn), 1);
    rd_m = rd_m + 16'd1;
    for (int t = 0; t < 25; t++) begin
      if (buf_ctr_C == rd_m) begin
        buf_ctr_C = buf_ctr_C + 16'($urandom_range(1, 3));
        settle(2);
      end
      run_xfer(int'($urandom_range(0, 40)), 2);
    end
    check("rand_no_overrun", 32'(overrun_C), 0);
    buf_ctr_C = rd_m + 16'd1;
    settle(2);
    xfer_words_C = 11'd600;
    drive(0, 0, 1, 1);
    rx = 0;
    for (int i = 0; i < 200 && rx < 100; i++) begin
      drive(0, 0, 0, 1);
      rx += int'(get_rx_samp_C);
    end
    drive(1, 0, 0, 1);
    buf_ctr_C = 16'd1;
    rd_m = '0;
    drive(0, 0, 0, 1);
    check("mid_read_reset", 32'({reset_bufs_C, get_rx_samp_C, get_buf_ctr_C, busy_C, done_C, overrun_C, avail_C}), 0);
    drive(0, 0, 0, 1);
    check("post_reset_avail", 32'(avail_C), 1);
    run_xfer(5, 0);
    buf_ctr_C = 16'd2;
    settle(2);
    xfer_words_C = 11'd50;
    drive(0, 0, 1, 1);
    rx = 0;
    for (int i = 0; i < 40 && rx < 10; i++) begin
      drive(0, 0, 0, 1);
      rx += int'(get_rx_samp_C);
    end
    drive(0, 1, 0, 0);
    buf_ctr_C = 16'd0;
    rd_m = '0;
    bz = 0;
    st = 0;
    dn = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1);
      bz += int'(busy_C);
      dn += int'(done_C);
      st += int'(get_rx_samp_C) + int'(get_buf_ctr_C);
    end
    check("abort_busy", 32'(bz), 9);
    check("abort_done", 32'(dn), 0);
    check("abort_strobes", 32'(st), 0);
    check("abort_avail", 32'(avail_C), 0);
    buf_ctr_C = 16'd8;
    settle(3);
    check("ahead8_avail", 32'(avail_C), 8);
    check("ahead8_overrun", 32'(overrun_C), 0);
    buf_ctr_C = 16'd9;
    settle(3);
    check("ahead9_avail", 32'(avail_C), 9);
    check("ahead9_overrun", 32'(overrun_C), 1);
    buf_ctr_C = 16'd0;
    settle(3);
    check("overrun_sticky", 32'(overrun_C), 1);
    drive(0, 1, 0, 0);
    settle(12);
    check("init_clears_overrun", 32'(overrun_C), 0);
    check("init_avail", 32'(avail_C), 0);
    buf_ctr_C = 16'hFFFF;
    settle(3);
    check("wrap_avail", 32'(avail_C), 32'hFFFF);
    check("wrap_overrun", 32'(overrun_C), 1);
    drive(1, 0, 0, 0);
    buf_ctr_C = 16'd0;
    drive(0, 0, 0, 0);
    check("reset_clears_overrun", 32'(overrun_C), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
